// File: rtl/pulse_train_gen.sv
// pulse_train_gen: BCD X.Y ms high/low times -> periodic waveform plus period-start strobe (option: PULSE_TRAIN_RESTART_EN).
// Latency: signal_out/signal_cycle change 1 clk after the tick edge that decides them.
// Backpressure: none; tick is a free-running strobe and en=0 parks the block in START.
module pulse_train_gen #(
  parameter int   CNT_W      = 7,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        tick,
  input  logic [15:0] tph,
  input  logic [15:0] tpl,
  output logic        signal_out,
  output logic        signal_cycle,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_IDLE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] sl_q, sl_d;
  logic [CNT_W-1:0] dec_h, dec_l;
  logic             strobe_q, strobe_d;
  logic             ps;
  logic             abort;
  logic             unused_bits;

  function automatic logic [CNT_W-1:0] bcd_ticks(input logic [3:0] units, input logic [3:0] tenths);
    logic [CNT_W-1:0] u;
    logic [CNT_W-1:0] t;
    u = (units  > 4'd9) ? CNT_W'(9) : CNT_W'(units);
    t = (tenths > 4'd9) ? CNT_W'(9) : CNT_W'(tenths);
    return (u << 3) + (u << 1) + t;
  endfunction

  assign dec_h       = bcd_ticks(tph[11:8], tph[3:0]);
  assign dec_l       = bcd_ticks(tpl[11:8], tpl[3:0]);
  // Decimal point and the upper nibble of each digit byte carry no timing information.
  assign unused_bits = ^{tph[15:12], tph[7:4], tpl[15:12], tpl[7:4]};

`ifdef PULSE_TRAIN_RESTART_EN
  logic [CNT_W-1:0] dec_h_q, dec_l_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_h_q <= '0;
      dec_l_q <= '0;
    end else begin
      dec_h_q <= dec_h;
      dec_l_q <= dec_l;
    end
  end

  // A running period is dropped back to START; the next tick then restarts with fresh values.
  assign abort = ((state_q == ST_HIGH) || (state_q == ST_LOW)) &&
                 ((dec_h_q != sh_q) || (dec_l_q != sl_q));
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    sl_d     = sl_q;
    strobe_d = 1'b0;
    ps       = 1'b0;
    if (tick) begin
      case (state_q)
        ST_START, ST_IDLE: ps = 1'b1;
        ST_HIGH: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (sl_q != '0) begin
            state_d = ST_LOW;
            cnt_d   = sl_q - CNT_W'(1);
          end else begin
            ps = 1'b1;
          end
        end
        ST_LOW: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          else             ps    = 1'b1;
        end
      endcase
    end
    // Period start: the only point where new tph/tpl values are accepted.
    if (ps) begin
      sh_d = dec_h;
      sl_d = dec_l;
      if ((dec_h == '0) && (dec_l == '0)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        strobe_d = 1'b1;
        if (dec_h != '0) begin
          state_d = ST_HIGH;
          cnt_d   = dec_h - CNT_W'(1);
        end else begin
          state_d = ST_LOW;
          cnt_d   = dec_l - CNT_W'(1);
        end
      end
    end else if (abort) begin
      state_d = ST_START;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_START;
      cnt_q        <= '0;
      sh_q         <= '0;
      sl_q         <= '0;
      strobe_q     <= 1'b0;
      signal_out   <= IDLE_LEVEL;
      signal_cycle <= 1'b0;
    end else if (!en) begin
      state_q      <= ST_START;
      cnt_q        <= '0;
      strobe_q     <= 1'b0;
      signal_out   <= IDLE_LEVEL;
      signal_cycle <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      sl_q         <= sl_d;
      strobe_q     <= strobe_d;
      // Outputs follow the state decided on the previous edge, a fixed 1-clk lag from tick.
      signal_out   <= (state_q == ST_HIGH) ? 1'b1 :
                      (state_q == ST_LOW)  ? 1'b0 : IDLE_LEVEL;
      signal_cycle <= strobe_q;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: vector table, corner-case sequences and a randomized run against a period-position model.
module tb_pulse_train_gen;

  logic        clk;
  logic        reset;
  logic        en;
  logic        tick;
  logic [15:0] tph;
  logic [15:0] tpl;
  logic        signal_out;
  logic        signal_cycle;
  logic [1:0]  state;

  int   total    = 0;
  int   bad      = 0;
  int   tick_per = 0;
  logic man_tick = 1'b0;
  bit   chk_on   = 1'b0;

  typedef struct {
    logic [15:0] tph;
    logic [15:0] tpl;
    int          tp;
    int          per_t;
    int          hi_t;
  } vec_t;

  pulse_train_gen dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .tick         (tick),
    .tph          (tph),
    .tpl          (tpl),
    .signal_out   (signal_out),
    .signal_cycle (signal_cycle),
    .state        (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // tick source: periodic (tick_per>0), random (tick_per<0) or manual copy of man_tick.
  initial begin : tick_gen
    int c;
    c    = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (tick_per > 0) begin
        c++;
        if (c >= tick_per) begin
          c    = 0;
          tick = 1'b1;
        end else begin
          tick = 1'b0;
        end
      end else if (tick_per < 0) begin
        c    = 0;
        tick = ($urandom_range(0, 2) == 0);
      end else begin
        c    = 0;
        tick = man_tick;
      end
    end
  end

  // Reference: position within the current period, counted in ticks since the last period start.
  int         m_mode = 0;  // 0 stopped, 1 running, 2 idle
  int         m_h    = 0;
  int         m_l    = 0;
  int         m_pos  = 0;
  bit         m_str  = 1'b0;
  logic       exp_out   = 1'b0;
  logic       exp_cyc   = 1'b0;
  logic [1:0] exp_state = 2'd0;

  function automatic int dec(input logic [15:0] v);
    int u;
    int t;
    u = int'(v[11:8]);
    t = int'(v[3:0]);
    if (u > 9) u = 9;
    if (t > 9) t = 9;
    return u * 10 + t;
  endfunction

  always @(posedge clk) begin : model
    logic o_n;
    logic c_n;
    o_n   = (m_mode == 1 && m_pos < m_h) ? 1'b1 : 1'b0;
    c_n   = m_str;
    m_str = 1'b0;
    if (!reset || !en) begin
      m_mode = 0;
      o_n    = 1'b0;
      c_n    = 1'b0;
    end else if (tick) begin
      if (m_mode == 1) m_pos++;
      if (m_mode != 1 || m_pos >= m_h + m_l) begin
        m_h   = dec(tph);
        m_l   = dec(tpl);
        m_pos = 0;
        if (m_h + m_l == 0) m_mode = 2;
        else begin
          m_mode = 1;
          m_str  = 1'b1;
        end
      end
    end
    exp_out   = o_n;
    exp_cyc   = c_n;
    exp_state = (m_mode == 0) ? 2'd0 : (m_mode == 2) ? 2'd3 : (m_pos < m_h) ? 2'd1 : 2'd2;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model signal_out", 32'(signal_out), 32'(exp_out));
      chk("model signal_cycle", 32'(signal_cycle), 32'(exp_cyc));
      chk("model state", 32'(state), 32'(exp_state));
    end
  end

  task automatic apply_reset();
    tick_per = 0;
    man_tick = 1'b0;
    reset    = 1'b0;
    en       = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Clocks from one strobe to the next, and how many of them had signal_out high.
  task automatic measure(input int chg_at, input logic [15:0] chg_tph, output int per, output int hi);
    int n;
    n   = 0;
    per = 0;
    hi  = 0;
    while (signal_cycle !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (signal_cycle !== 1'b1) begin
      per = -1;
      hi  = -1;
      return;
    end
    do begin
      if (per == chg_at) tph = chg_tph;
      if (signal_out === 1'b1) hi++;
      per++;
      @(negedge clk);
    end while (signal_cycle !== 1'b1 && per < 20000);
  endtask

  task automatic wait_state(input logic [1:0] s, input string nm);
    int n;
    n = 0;
    while (state !== s && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(state), 32'(s));
  endtask

  function automatic logic [15:0] rnd_time();
    logic [15:0] v;
    v       = 16'($urandom);
    v[11:8] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 2));
    return v;
  endfunction

  initial begin : main
    vec_t vecs[6];
    int   per;
    int   hi;
    int   n;
    int   r;

    vecs[0] = '{16'h8105, 16'h8003, 10, 18, 15};
    vecs[1] = '{16'h8F0C, 16'h8001, 2, 100, 99};
    vecs[2] = '{16'h8200, 16'h8000, 3, 20, 20};
    vecs[3] = '{16'h8000, 16'h8004, 3, 4, 0};
    vecs[4] = '{16'h8307, 16'h8F00, 2, 127, 37};
    vecs[5] = '{16'h70F1, 16'h5A32, 2, 93, 1};

    tph   = 16'h0;
    tpl   = 16'h0;
    en    = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset signal_out", 32'(signal_out), 32'd0);
    chk("reset signal_cycle", 32'(signal_cycle), 32'd0);
    chk("reset state", 32'(state), 32'd0);
    chk_on = 1'b1;

    for (int i = 0; i < 6; i++) begin
      apply_reset();
      tph      = vecs[i].tph;
      tpl      = vecs[i].tpl;
      en       = 1'b1;
      tick_per = vecs[i].tp;
      measure(-1, 16'h0, per, hi);
      chk($sformatf("vec%0d period", i), 32'(per), 32'(vecs[i].per_t * vecs[i].tp));
      chk($sformatf("vec%0d high", i), 32'(hi), 32'(vecs[i].hi_t * vecs[i].tp));
    end

    // First strobe lands one clk after the first tick's decision edge.
    apply_reset();
    tph = 16'h8105;
    tpl = 16'h8003;
    en  = 1'b1;
    @(negedge clk);
    man_tick = 1'b1;
    @(negedge clk);
    man_tick = 1'b0;
    chk("first tick state", 32'(state), 32'd1);
    chk("first tick no early strobe", 32'(signal_cycle), 32'd0);
    @(negedge clk);
    chk("first strobe", 32'(signal_cycle), 32'd1);
    chk("first high", 32'(signal_out), 32'd1);
    @(negedge clk);
    chk("strobe one clk", 32'(signal_cycle), 32'd0);

    // Both times zero: IDLE, no strobes, then leave on a nonzero high time.
    apply_reset();
    tph      = 16'h8000;
    tpl      = 16'h8000;
    en       = 1'b1;
    tick_per = 3;
    n        = 0;
    repeat (30) begin
      @(negedge clk);
      if (signal_cycle === 1'b1) n++;
    end
    chk("idle strobes", 32'(n), 32'd0);
    chk("idle state", 32'(state), 32'd3);
    chk("idle out", 32'(signal_out), 32'd0);
    tph = 16'h8200;
    measure(-1, 16'h0, per, hi);
    chk("idle exit period", 32'(per), 32'd60);
    chk("idle exit high", 32'(hi), 32'd60);

    // Mid-HIGH change of tph waits for the next period start.
    apply_reset();
    tph      = 16'h8105;
    tpl      = 16'h8003;
    en       = 1'b1;
    tick_per = 3;
    measure(15, 16'h8002, per, hi);
    chk("midchg cur period", 32'(per), 32'd54);
    chk("midchg cur high", 32'(hi), 32'd45);
    measure(-1, 16'h0, per, hi);
    chk("midchg next period", 32'(per), 32'd15);
    chk("midchg next high", 32'(hi), 32'd6);

    // Reset in the middle of LOW.
    apply_reset();
    tph      = 16'h8105;
    tpl      = 16'h8003;
    en       = 1'b1;
    tick_per = 3;
    wait_state(2'd2, "reach LOW");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst mid out", 32'(signal_out), 32'd0);
    chk("rst mid cycle", 32'(signal_cycle), 32'd0);
    chk("rst mid state", 32'(state), 32'd0);
    reset = 1'b1;
    measure(-1, 16'h0, per, hi);
    chk("rst resume period", 32'(per), 32'd54);
    chk("rst resume high", 32'(hi), 32'd45);

    // en dropped for 3 ticks mid-HIGH.
    apply_reset();
    tph      = 16'h8105;
    tpl      = 16'h8003;
    en       = 1'b1;
    tick_per = 3;
    wait_state(2'd1, "reach HIGH");
    repeat (6) @(negedge clk);
    en = 1'b0;
    repeat (9) @(negedge clk);
    chk("en off out", 32'(signal_out), 32'd0);
    chk("en off state", 32'(state), 32'd0);
    chk("en off cycle", 32'(signal_cycle), 32'd0);
    en = 1'b1;
    measure(-1, 16'h0, per, hi);
    chk("en resume period", 32'(per), 32'd54);
    chk("en resume high", 32'(hi), 32'd45);

    // Randomized run checked cycle by cycle against the model.
    apply_reset();
    en       = 1'b1;
    tph      = rnd_time();
    tpl      = rnd_time();
    tick_per = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      r     = int'($urandom_range(0, 999));
      reset = 1'b1;
      if (r < 10)                 tph   = rnd_time();
      else if (r < 20)            tpl   = rnd_time();
      else if (r < 24)            en    = ~en;
      else if (r < 26)            reset = 1'b0;
      else if (r < 60 && !en)     en    = 1'b1;
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
Pulse-mode waveform stage. It sits directly downstream of the tph/tpl registers that the top-level saves from the time-pulse editor. It converts the two display-format BCD time values (X.Y ms, 0.1 ms resolution) into a periodic high/low waveform on signal_out, and emits a one-clock signal_cycle strobe at the start of every period. New tph/tpl values take effect only at a period boundary, so edits never produce runt pulses.

Parameters:
CNT_W, 7, tick counter width; must hold 99.
IDLE_LEVEL, 1'b0, signal_out level in START/IDLE and while disabled.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
en  in  1  block enable; 0 forces START
tick  in  1  100 us time-base strobe, one clk wide (clk_ev_100us)
tph  in  16  high time, display format: [15] dp (ignored), [11:8] units BCD, [3:0] tenths BCD; other bits ignored
tpl  in  16  low time, same format
signal_out  out  1  generated waveform, registered
signal_cycle  out  1  one-clk strobe at each period start, registered
state  out  2  FSM state for debug/CV: 0 START, 1 HIGH, 2 LOW, 3 IDLE

Behaviour:
- Reset (reset==0 at clk edge): state=START, counter=0, shadow_h=shadow_l=0, signal_out=IDLE_LEVEL, signal_cycle=0. Reset overrides all other inputs, including mid-pulse.
- Decode: ticks = units*10 + tenths. Any digit >9 clamps to 9. Range 0..99 ticks (0.0 to 9.9 ms).
- Period start (PS): on a tick while in START, at the end of LOW, or at the end of HIGH when shadow_l==0. At PS:
  - latch shadow_h/shadow_l from the decoded tph/tpl;
  - if both are 0: go to IDLE, no strobe;
  - if shadow_h>0: go to HIGH, counter=shadow_h-1;
  - if shadow_h==0: go to LOW, counter=shadow_l-1;
  - assert signal_cycle for 1 clk.
- HIGH: signal_out=1. On each tick: if counter>0, decrement; else end of HIGH. End of HIGH goes to LOW with counter=shadow_l-1, or performs PS if shadow_l==0.
- LOW: signal_out=0. On each tick: if counter>0, decrement; else PS.
- IDLE: signal_out=IDLE_LEVEL. On each tick, re-decode tph/tpl; leave through PS if either is nonzero.
- Timing:
  - state, counter and strobe update on the clk edge where tick==1.
  - signal_out and signal_cycle are registered and change on the edge after the decision, giving a fixed 1-clk latency from tick.
  - High time is exactly shadow_h ticks; period is exactly (shadow_h+shadow_l) ticks.
- Edge cases:
  - tph=0, tpl>0: signal_out held 0, strobe every tpl ticks.
  - tpl=0, tph>0: signal_out held 1, strobe every tph ticks.
- Input changes mid-period are ignored until the next PS.
- en=0: synchronous return to START, signal_out=IDLE_LEVEL, signal_cycle=0. When en returns to 1, the first tick performs PS.
- tick is ignored while en==0 or reset==0.
- Counter never wraps: it only decrements when >0.

Optional Feature:
Macro PULSE_TRAIN_RESTART_EN.
- Defined: the block registers the decoded tph/tpl every clk. If either value differs from its shadow while in HIGH or LOW, the current period is aborted and the next tick performs PS with the new values. signal_out goes low for at most 1 tick before the restart.
- Undefined: changes apply only at the natural period boundary, as described under Behaviour.

Test Plan:
1. Reset, en=1, tph=16'h8105 (1.5), tpl=16'h8003 (0.3), tick every 10 clk -> signal_out high 15 ticks, low 3 ticks; signal_cycle period 18 ticks; first strobe 1 clk after the first tick.
2. tph=16'h8000, tpl=16'h8000 -> state=IDLE, signal_out=0, no strobes. Then set tph=16'h8200 -> at the next tick, signal_out=1 continuously with a strobe every 20 ticks.
3. During HIGH of case 1, change tph to 16'h8002 -> current period keeps 15/3; the next period is 0.2/0.3 (2 high, 3 low). With PULSE_TRAIN_RESTART_EN defined -> restart on the next tick with 2/3.
4. tph=16'h8F0C (invalid digits), tpl=16'h8001 -> high 99 ticks, low 1 tick.
5. Assert reset low mid-LOW, then release -> outputs 0, state=START; resumes at the first tick with no runt strobe.
6. Drop en for 3 ticks mid-HIGH -> signal_out=IDLE_LEVEL, state=START; after en=1, the first tick performs PS with a full high time.
